// File: rtl/port_io_pkg.sv
// Shared types, defaults and slice helper for the port I/O frame transmitter.
// The optional parity word is enabled with `define PORT_IO_PARITY_EN.
package port_io_pkg;

   localparam int DEF_PORT_COUNT = 10;
   localparam int DEF_PORT_WIDTH = 8;
   localparam int DEF_CLK_DIV    = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SEND,
      ST_PARITY
   } state_e;

   function automatic int port_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/port_io_frame_tx_if.sv
// Port I/O link bundle: port snapshot inputs plus the framed bus outputs.
// The bench drives through master; the transmitter uses slave.
interface port_io_frame_tx_if
   import port_io_pkg::*;
#(
   parameter int PORT_COUNT = DEF_PORT_COUNT,
   parameter int PORT_WIDTH = DEF_PORT_WIDTH
);
   logic                             enable;
   logic [PORT_COUNT*PORT_WIDTH-1:0] port_val;
   logic [PORT_COUNT*PORT_WIDTH-1:0] port_dir;
   logic                             port_clk;
   logic                             port_rst;
   logic [PORT_WIDTH-1:0]            data;
   logic                             busy;
   logic                             frame_done;

   modport master (
      output enable, port_val, port_dir,
      input  port_clk, port_rst, data, busy, frame_done
   );

   modport slave (
      input  enable, port_val, port_dir,
      output port_clk, port_rst, data, busy, frame_done
   );
endinterface

// File: rtl/port_io_clkgen.sv
// Bit-period divider: port_clk low for CLK_DIV cycles, then high for CLK_DIV,
// with first/last-cycle strobes for the frame FSM.
module port_io_clkgen
   import port_io_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   output logic o_port_clk,
   output logic o_period_start,
   output logic o_period_end
);
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] C_LAST = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] C_RISE = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_port_clk;

   // Counter parks at zero while idle so every frame starts on a period edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_port_clk <= 1'b0;
      end else if (!i_run) begin
         r_cnt      <= '0;
         r_port_clk <= 1'b0;
      end else if (r_cnt == C_LAST) begin
         r_cnt      <= '0;
         r_port_clk <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == C_RISE) r_port_clk <= 1'b1;
      end
   end

   assign o_port_clk     = r_port_clk;
   assign o_period_start = i_run && (r_cnt == '0);
   assign o_period_end   = i_run && (r_cnt == C_LAST);
endmodule

// File: rtl/port_io_frame_tx.sv
// Port-expander transmitter: SYNC period, then dir/val word pairs per port.
// Define PORT_IO_PARITY_EN to append an XOR parity word to each frame.
module port_io_frame_tx
   import port_io_pkg::*;
#(
   parameter int PORT_COUNT = DEF_PORT_COUNT,
   parameter int PORT_WIDTH = DEF_PORT_WIDTH,
   parameter int CLK_DIV    = DEF_CLK_DIV
) (
   input  logic               clk,
   input  logic               rst,
   port_io_frame_tx_if.slave  bus
);
   localparam int NW = 2 * PORT_COUNT;
   localparam int KW = $clog2(NW);
   localparam int BW = PORT_COUNT * PORT_WIDTH;
   localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

   state_e                r_state;
   logic [KW-1:0]         r_k;
   logic [KW-1:0]         w_nk;
   logic [BW-1:0]         r_val;
   logic [BW-1:0]         r_dir;
   logic [PORT_WIDTH-1:0] r_data;
   logic [PORT_WIDTH-1:0] w_word;
   logic                  r_port_rst;
   logic                  r_busy;
   logic                  r_last;
   logic                  w_run;
   logic                  w_pstart;
   logic                  w_pend;
   logic                  w_final;
   logic                  w_end;

   assign w_run = (r_state != ST_IDLE);

   port_io_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk            (clk),
      .rst            (rst),
      .i_run          (w_run),
      .o_port_clk     (bus.port_clk),
      .o_period_start (w_pstart),
      .o_period_end   (w_pend)
   );

   // Word index for the next period: even = direction, odd = value.
   always_comb begin
      w_nk = '0;
      if (r_state == ST_SEND && r_k != K_LAST) w_nk = r_k + 1'b1;
      if (w_nk[0])
         w_word = r_val[port_lsb(int'(w_nk >> 1), PORT_WIDTH) +: PORT_WIDTH];
      else
         w_word = r_dir[port_lsb(int'(w_nk >> 1), PORT_WIDTH) +: PORT_WIDTH];
   end

`ifdef PORT_IO_PARITY_EN
   logic [PORT_WIDTH-1:0] w_par;

   always_comb begin
      w_par = '0;
      for (int i = 0; i < PORT_COUNT; i++)
         w_par = w_par ^ r_val[i*PORT_WIDTH +: PORT_WIDTH]
                       ^ r_dir[i*PORT_WIDTH +: PORT_WIDTH];
   end

   assign w_final = (r_state == ST_PARITY);
`else
   assign w_final = (r_state == ST_SEND) && (r_k == K_LAST);
`endif

   assign w_end = w_pend && w_final;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_k        <= '0;
         r_val      <= '0;
         r_dir      <= '0;
         r_data     <= '0;
         r_port_rst <= 1'b1;
         r_busy     <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         if (w_pstart)   r_last <= w_final;
         else if (w_end) r_last <= 1'b0;

         // Frame boundary: restart straight into SYNC or fall back to IDLE.
         if (w_end || (r_state == ST_IDLE && bus.enable)) begin
            r_k        <= '0;
            r_data     <= '0;
            r_port_rst <= 1'b1;
            if (bus.enable) begin
               r_state <= ST_SYNC;
               r_busy  <= 1'b1;
               r_val   <= bus.port_val;
               r_dir   <= bus.port_dir;
            end else begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         end else if (w_pend) begin
            unique case (r_state)
               ST_SYNC: begin
                  r_state    <= ST_SEND;
                  r_port_rst <= 1'b0;
                  r_data     <= w_word;
               end
               ST_SEND: begin
                  if (r_k == K_LAST) begin
`ifdef PORT_IO_PARITY_EN
                     r_state <= ST_PARITY;
                     r_data  <= w_par;
`endif
                  end else begin
                     r_k    <= w_nk;
                     r_data <= w_word;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.port_rst   = r_port_rst;
   assign bus.data       = r_data;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_last && w_pend;
endmodule
